// File: rtl/pc_cfr_cpa_if.sv
// ---------------------------------------------------------------------------
// pc_cfr_cpa_if
// Bundle between the peak detector / control plane and the cancellation
// pulse allocator (pc_cfr_cpa).
//   peak_r, peak_theta, peak_phase, peak_valid : peak stream into allocator
//   ctrl_enable                                 : allow new allocations
//   stat_clear                                  : clear drop counter
//   cpg_valid/addr/r/theta/phase                : per-slot CPG drive, slice k
//   stat_drop_count                             : dropped-peak counter
// Modports: master = peak/control source, slave = allocator.
// ---------------------------------------------------------------------------
interface pc_cfr_cpa_if #(
   parameter int ITERATIONS = 7,
   parameter int DATA_WIDTH = 16,
   parameter int NUM_CPG    = 4,
   parameter int PULSE_LEN  = 64
);
   localparam int ADDR_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

   logic [DATA_WIDTH:0]                 peak_r;
   logic [ITERATIONS:0]                 peak_theta;
   logic                                peak_phase;
   logic                                peak_valid;
   logic                                ctrl_enable;
   logic                                stat_clear;
   logic [NUM_CPG-1:0]                  cpg_valid;
   logic [NUM_CPG*ADDR_W-1:0]           cpg_addr;
   logic [NUM_CPG*(DATA_WIDTH+1)-1:0]   cpg_r;
   logic [NUM_CPG*(ITERATIONS+1)-1:0]   cpg_theta;
   logic [NUM_CPG-1:0]                  cpg_phase;
   logic [15:0]                         stat_drop_count;

   modport master (
      output peak_r, peak_theta, peak_phase, peak_valid, ctrl_enable, stat_clear,
      input  cpg_valid, cpg_addr, cpg_r, cpg_theta, cpg_phase, stat_drop_count
   );

   modport slave (
      input  peak_r, peak_theta, peak_phase, peak_valid, ctrl_enable, stat_clear,
      output cpg_valid, cpg_addr, cpg_r, cpg_theta, cpg_phase, stat_drop_count
   );
endinterface

// File: rtl/pc_cfr_cpa.sv
// ---------------------------------------------------------------------------
// pc_cfr_cpa
// Cancellation pulse allocator for peak-cancellation CFR. Each accepted peak
// is placed in the lowest-index free generator slot; a busy slot sweeps its
// coefficient address 0..PULSE_LEN-1 (one address per clk) and then idles,
// unless it is re-allocated on its last address (back-to-back, no gap).
// Ports:
//   clk     : clock
//   rst     : synchronous reset, active-high, clears every slot and counter
//   cpa_if  : pc_cfr_cpa_if.slave (peak input, control, per-slot CPG outputs)
// Optional feature macro: PC_CFR_CPA_DROP_CNT_EN
//   defined   -> saturating 16-bit dropped-peak counter, stat_clear wins
//   undefined -> stat_drop_count tied to 0, stat_clear ignored
// ---------------------------------------------------------------------------
module pc_cfr_cpa #(
   parameter int ITERATIONS = 7,
   parameter int DATA_WIDTH = 16,
   parameter int NUM_CPG    = 4,
   parameter int PULSE_LEN  = 64
) (
   input  logic          clk,
   input  logic          rst,
   pc_cfr_cpa_if.slave   cpa_if
);
   localparam int ADDR_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
   localparam int R_W    = DATA_WIDTH + 1;
   localparam int TH_W   = ITERATIONS + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PULSE_LEN - 1);

   typedef enum logic {ST_IDLE, ST_BUSY} slot_st_e;

   slot_st_e          st_q    [NUM_CPG];
   logic [ADDR_W-1:0] addr_q  [NUM_CPG];
   logic [R_W-1:0]    r_q     [NUM_CPG];
   logic [TH_W-1:0]   theta_q [NUM_CPG];
   logic              phase_q [NUM_CPG];

   logic [NUM_CPG-1:0] last_w;
   logic [NUM_CPG-1:0] alloc_oh_w;
   logic               alloc_req_w;
   logic               drop_w;

   // Slot selection: a slot on its final address counts as free so a new
   // pulse can follow the old one without an idle cycle. The first free slot
   // found clears drop_w, which also blocks any higher-index slot.
   always_comb begin
      alloc_req_w = cpa_if.peak_valid && cpa_if.ctrl_enable;
      alloc_oh_w  = '0;
      last_w      = '0;
      drop_w      = alloc_req_w;
      for (int k = 0; k < NUM_CPG; k++) begin
         last_w[k] = (st_q[k] == ST_BUSY) && (addr_q[k] == LAST_ADDR);
         if (drop_w && ((st_q[k] == ST_IDLE) || last_w[k])) begin
            alloc_oh_w[k] = 1'b1;
            drop_w        = 1'b0;
         end
      end
   end

   // Per-slot state machine; idle slots hold all fields at zero so the
   // downstream multipliers never see stale amplitude/angle.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NUM_CPG; k++) begin
            st_q[k]    <= ST_IDLE;
            addr_q[k]  <= '0;
            r_q[k]     <= '0;
            theta_q[k] <= '0;
            phase_q[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < NUM_CPG; k++) begin
            if (alloc_oh_w[k]) begin
               st_q[k]    <= ST_BUSY;
               addr_q[k]  <= '0;
               r_q[k]     <= cpa_if.peak_r;
               theta_q[k] <= cpa_if.peak_theta;
               phase_q[k] <= cpa_if.peak_phase;
            end else if (last_w[k]) begin
               st_q[k]    <= ST_IDLE;
               addr_q[k]  <= '0;
               r_q[k]     <= '0;
               theta_q[k] <= '0;
               phase_q[k] <= 1'b0;
            end else if (st_q[k] == ST_BUSY) begin
               addr_q[k]  <= addr_q[k] + ADDR_W'(1);
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CPG; g++) begin : g_slot_out
      assign cpa_if.cpg_valid[g]                    = (st_q[g] == ST_BUSY);
      assign cpa_if.cpg_addr[g*ADDR_W +: ADDR_W]    = addr_q[g];
      assign cpa_if.cpg_r[g*R_W +: R_W]             = r_q[g];
      assign cpa_if.cpg_theta[g*TH_W +: TH_W]       = theta_q[g];
      assign cpa_if.cpg_phase[g]                    = phase_q[g];
   end

`ifdef PC_CFR_CPA_DROP_CNT_EN
   logic [15:0] drop_cnt_q;
   logic [15:0] drop_cnt_d;

   // Clear has priority over a simultaneous drop; count saturates at all-ones.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (cpa_if.stat_clear) begin
         drop_cnt_d = '0;
      end else if (drop_w && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign cpa_if.stat_drop_count = drop_cnt_q;
`else
   logic unused_sig;
   assign unused_sig             = ^{cpa_if.stat_clear, drop_w};
   assign cpa_if.stat_drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_pc_cfr_cpa.sv
module tb_pc_cfr_cpa;
   localparam int NC = 4;
   localparam int PL = 8;
   localparam int AW = 3;

   logic clk;
   logic rst;

   pc_cfr_cpa_if #(.ITERATIONS(7), .DATA_WIDTH(16), .NUM_CPG(NC), .PULSE_LEN(PL)) b ();
   pc_cfr_cpa_if #(.ITERATIONS(7), .DATA_WIDTH(16), .NUM_CPG(1), .PULSE_LEN(64)) b2 ();

   pc_cfr_cpa #(.ITERATIONS(7), .DATA_WIDTH(16), .NUM_CPG(NC), .PULSE_LEN(PL)) dut (
      .clk(clk), .rst(rst), .cpa_if(b)
   );
   pc_cfr_cpa #(.ITERATIONS(7), .DATA_WIDTH(16), .NUM_CPG(1), .PULSE_LEN(64)) dut_sat (
      .clk(clk), .rst(rst), .cpa_if(b2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [NC-1:0]    v;
      logic [NC*AW-1:0] addr;
      logic [NC*17-1:0] r;
      logic [NC*8-1:0]  th;
      logic [NC-1:0]    ph;
      logic [15:0]      cnt;
   } exp_t;

   exp_t q[$];

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   // reference model: each slot remembers the cycle its pulse started
   int          cyc = 0;
   bit          m_busy  [NC];
   int          m_start [NC];
   logic [16:0] m_r     [NC];
   logic [7:0]  m_th    [NC];
   logic        m_ph    [NC];
   logic [15:0] m_cnt = 16'd0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick(input logic v, input logic [16:0] r, input logic [7:0] th,
                       input logic ph, input logic en, input logic clr, input logic rs);
      exp_t e;
      exp_t got;
      int   slot;
      bit   drop;
      b.peak_valid  = v;
      b.peak_r      = r;
      b.peak_theta  = th;
      b.peak_phase  = ph;
      b.ctrl_enable = en;
      b.stat_clear  = clr;
      rst           = rs;
      drop = 1'b0;
      if (rs) begin
         for (int k = 0; k < NC; k++) m_busy[k] = 1'b0;
         m_cnt = 16'd0;
      end else begin
         slot = -1;
         for (int k = 0; k < NC; k++)
            if (slot < 0 && (!m_busy[k] || (cyc - m_start[k]) == PL - 1)) slot = k;
         for (int k = 0; k < NC; k++)
            if (m_busy[k] && (cyc - m_start[k]) == PL - 1) m_busy[k] = 1'b0;
         if (v && en) begin
            if (slot >= 0) begin
               m_busy[slot]  = 1'b1;
               m_start[slot] = cyc + 1;
               m_r[slot]     = r;
               m_th[slot]    = th;
               m_ph[slot]    = ph;
            end else begin
               drop = 1'b1;
            end
         end
`ifdef PC_CFR_CPA_DROP_CNT_EN
         if (clr) m_cnt = 16'd0;
         else if (drop && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
      end
      cyc++;
      e = '0;
      for (int k = 0; k < NC; k++) begin
         if (m_busy[k]) begin
            e.v[k]             = 1'b1;
            e.addr[k*AW +: AW] = AW'(cyc - m_start[k]);
            e.r[k*17 +: 17]    = m_r[k];
            e.th[k*8 +: 8]     = m_th[k];
            e.ph[k]            = m_ph[k];
         end
      end
      e.cnt = m_cnt;
      q.push_back(e);
      @(posedge clk);
      #1;
      got = q.pop_front();
      chk("sb_valid", 128'(b.cpg_valid), 128'(got.v));
      chk("sb_addr",  128'(b.cpg_addr),  128'(got.addr));
      chk("sb_r",     128'(b.cpg_r),     128'(got.r));
      chk("sb_theta", 128'(b.cpg_theta), 128'(got.th));
      chk("sb_phase", 128'(b.cpg_phase), 128'(got.ph));
      chk("sb_cnt",   128'(b.stat_drop_count), 128'(got.cnt));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 17'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      logic [15:0] one_drop;
      logic [15:0] sat_exp;
      int          sat_cycles;
`ifdef PC_CFR_CPA_DROP_CNT_EN
      one_drop   = 16'd1;
      sat_exp    = 16'hFFFF;
      sat_cycles = 71200;
`else
      one_drop   = 16'd0;
      sat_exp    = 16'd0;
      sat_cycles = 300;
`endif
      b2.peak_valid  = 1'b0;
      b2.peak_r      = 17'd9;
      b2.peak_theta  = 8'd3;
      b2.peak_phase  = 1'b0;
      b2.ctrl_enable = 1'b1;
      b2.stat_clear  = 1'b0;

      // reset state
      repeat (3) tick(1'b0, 17'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("rst_valid", 128'(b.cpg_valid), 128'd0);
      chk("rst_cnt", 128'(b.stat_drop_count), 128'd0);
      idle(2);

      // single peak: 8-cycle pulse in slot 0, then idle
      tick(1'b1, 17'd100, 8'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("single_valid", 128'(b.cpg_valid), 128'h1);
      chk("single_addr0", 128'(b.cpg_addr[2:0]), 128'd0);
      chk("single_r", 128'(b.cpg_r[16:0]), 128'd100);
      chk("single_theta", 128'(b.cpg_theta[7:0]), 128'd5);
      chk("single_phase", 128'(b.cpg_phase[0]), 128'd1);
      idle(7);
      chk("single_addr7", 128'(b.cpg_addr[2:0]), 128'd7);
      chk("single_still", 128'(b.cpg_valid), 128'h1);
      idle(1);
      chk("single_done", 128'(b.cpg_valid), 128'h0);
      chk("single_zero_r", 128'(b.cpg_r), 128'd0);

      // five peaks: four slots fill, fifth dropped
      for (int i = 1; i <= 5; i++) tick(1'b1, 17'(i), 8'(i + 20), 1'b0, 1'b1, 1'b0, 1'b0);
      chk("full_valid", 128'(b.cpg_valid), 128'hF);
      chk("full_slot0_r", 128'(b.cpg_r[16:0]), 128'd1);
      chk("full_slot3_r", 128'(b.cpg_r[67:51]), 128'd4);
      chk("full_drop_cnt", 128'(b.stat_drop_count), 128'(one_drop));
      // drop and clear together: clear wins
      tick(1'b1, 17'd6, 8'd6, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("clear_wins", 128'(b.stat_drop_count), 128'd0);
      idle(2);
      chk("slot0_last", 128'(b.cpg_addr[2:0]), 128'd7);
      // back-to-back reuse of slot 0
      tick(1'b1, 17'd77, 8'd12, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("reuse_valid0", 128'(b.cpg_valid[0]), 128'd1);
      chk("reuse_addr0", 128'(b.cpg_addr[2:0]), 128'd0);
      chk("reuse_r0", 128'(b.cpg_r[16:0]), 128'd77);
      idle(10);
      chk("drained", 128'(b.cpg_valid), 128'd0);

      // disabled: peak ignored, not a drop
      tick(1'b1, 17'd55, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("disabled_valid", 128'(b.cpg_valid), 128'd0);
      chk("disabled_cnt", 128'(b.stat_drop_count), 128'd0);
      idle(1);

      // reset mid-pulse aborts all slots
      tick(1'b1, 17'd11, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0);
      tick(1'b1, 17'd12, 8'd3, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(2);
      chk("pre_rst_busy", 128'(b.cpg_valid), 128'h3);
      tick(1'b0, 17'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("midrst_valid", 128'(b.cpg_valid), 128'd0);
      chk("midrst_addr", 128'(b.cpg_addr), 128'd0);
      chk("midrst_r", 128'(b.cpg_r), 128'd0);
      tick(1'b1, 17'd33, 8'd4, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("post_rst_slot0", 128'(b.cpg_valid), 128'h1);
      chk("post_rst_r", 128'(b.cpg_r[16:0]), 128'd33);
      idle(9);

      // counter saturation on a 1-slot, 64-long allocator (63 drops per pulse)
      b2.peak_valid = 1'b1;
      repeat (sat_cycles) @(posedge clk);
      #1;
      chk("sat_cnt", 128'(b2.stat_drop_count), 128'(sat_exp));
      b2.peak_valid = 1'b0;
      b2.stat_clear = 1'b1;
      @(posedge clk);
      #1;
      b2.stat_clear = 1'b0;
      chk("sat_clear", 128'(b2.stat_drop_count), 128'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
